cpu_bus_bridge: RTL and testbench
=================================

Name: cpu_bus_bridge

Overview:
Downstream of the 6502 core's multiplexed pin interface. Demultiplexes the time-shared address/data/rw pins into a flat 16-bit address, 8-bit data and write strobe. Runs one valid/ready transaction per CPU bus cycle against external memory. Drives read data back onto the CPU's data input before the next CPU clock edge.

Parameters:
TIMEOUT, 15, max clk cycles in REQ waiting for mem_ready before abort (1..255)
TIMEOUT_DATA, 8'hEA, byte returned to CPU on read timeout (NOP opcode)

Ports:
clk  in  1  system clock, same clk as the core
rst  in  1  synchronous reset, active-high
cpu_phase  in  1  core's clk_cpu level; 1 = address-low/rw phase, 0 = address-high/data phase
cpu_addr_mux  in  8  core uo_out: addr[7:0] when phase=1, addr[15:8] when phase=0
cpu_uio_out  in  8  core uio_out: bit0 = rw (1=write) when phase=1, write data when phase=0
cpu_uio_oe  in  8  core uio_oe; qualifies rw and write data
cpu_uio_in  out  8  read data presented to core uio_in
mem_addr  out  16  transaction address
mem_wdata  out  8  transaction write data
mem_we  out  1  1 = write transaction
mem_valid  out  1  request valid
mem_ready  in  1  memory accepts/completes request this cycle
mem_rdata  in  8  read data, valid when mem_valid & mem_ready & !mem_we
bus_busy  out  1  state != IDLE
err_timeout  out  1  sticky, set on any timeout
err_overrun  out  1  sticky, set when a bus cycle is dropped
cycle_count  out  16  count of completed transactions (incl. timeouts), wraps

Behaviour:
- Reset: all outputs 0; cpu_uio_in=0; state IDLE; phase_q=0; addr_lo/rw regs 0; timeout counter 0.
- phase_q = registered cpu_phase. Falling edge fe = phase_q & !cpu_phase.
- Every clk with cpu_phase=1: addr_lo <= cpu_addr_mux; rw_lat <= cpu_uio_out[0] & cpu_uio_oe[0]. Last cycle of phase 1 wins.
- FSM states IDLE, REQ, DONE.
- IDLE, on fe: mem_addr <= {cpu_addr_mux, addr_lo}; mem_we <= rw_lat; mem_wdata <= cpu_uio_out if rw_lat & cpu_uio_oe==8'hFF, else 0; mem_valid <= 1; tcnt <= 0; go to REQ.
- mem_valid asserts the cycle after fe; mem_addr/mem_we/mem_wdata stable while mem_valid=1.
- REQ, mem_ready=1: mem_valid <= 0; if !mem_we, cpu_uio_in <= mem_rdata; cycle_count++; go to DONE. Zero-wait memory gives 2-cycle fe-to-data latency.
- REQ, mem_ready=0: tcnt++. When tcnt==TIMEOUT-1 with no ready: mem_valid <= 0; err_timeout <= 1; on a read, cpu_uio_in <= TIMEOUT_DATA; cycle_count++; go to DONE.
- DONE: go to IDLE next clk. If fe occurs in DONE it is not lost: treat as IDLE-fe and launch directly (DONE to REQ).
- fe while in REQ: cycle dropped, err_overrun <= 1, the in-flight transaction continues.
- cpu_uio_in holds its value until the next completed read. Writes do not change it.
- Error flags clear only on rst.
- Reset mid-REQ: mem_valid drops the next clk and the transaction is abandoned.
- cycle_count wraps 16'hFFFF to 0.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2); constants RW_WRITE=1'b1, OE_ALL=8'hFF.
- One natural sub-module: bus_phase_capture, holding phase_q, fe detection and the addr_lo/rw_lat capture. The FSM, timeout and counters stay in the top.

Test Plan:
- Read, zero-wait: phase=1 with addr_mux=8'h34, uio_out=0, oe=1; then phase=0 with addr_mux=8'h12; mem_ready=1, rdata=8'hA9 -> mem_addr=16'h1234, mem_we=0, mem_valid high exactly 1 cycle, cpu_uio_in=8'hA9 two cycles after fe, cycle_count=1.
- Write: phase=1 with addr 8'hFF, uio_out bit0=1, oe=1; phase=0 with addr 8'h01, uio_out=8'h5C, oe=8'hFF -> mem_addr=16'h01FF, mem_we=1, mem_wdata=8'h5C, cpu_uio_in unchanged.
- Wait states: mem_ready low 3 cycles then high, rdata=8'h77 -> mem_valid high 4 cycles with address stable, cpu_uio_in=8'h77, no error.
- Timeout: read with mem_ready held low, TIMEOUT=15 -> mem_valid drops after 15 cycles, cpu_uio_in=8'hEA, err_timeout=1 and stays 1 across later good cycles.
- Overrun: second fe while in REQ -> err_overrun=1, first transaction completes with the original address, second cycle produces no mem_valid.
- Reset: assert rst during REQ -> next clk mem_valid=0, bus_busy=0, flags and cycle_count=0, cpu_uio_in=0.

Source files
------------

// File: rtl/cpu_bus_bridge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : cpu_bus_bridge_pkg                                      |
// | Purpose  : Shared types and constants for the 6502 bus bridge      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package cpu_bus_bridge_pkg;

    // Bridge transaction state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } bridge_state_e;

    localparam logic       RW_WRITE = 1'b1;
    localparam logic [7:0] OE_ALL   = 8'hFF;

    // Write data is only trusted when the core drives every data pin.
    function automatic logic [7:0] sel_wdata(
        input logic       rw,
        input logic [7:0] oe,
        input logic [7:0] data
    );
        return ((rw == RW_WRITE) && (oe == OE_ALL)) ? data : 8'h00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_bus_bridge_bus_phase_capture.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : bus_phase_capture                                       |
// | Purpose  : Tracks the CPU clock phase, flags its falling edge and  |
// |            latches address-low / rw from the first bus phase       |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module bus_phase_capture
    import cpu_bus_bridge_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_phase_i,
    input  logic [7:0] cpu_addr_mux_i,
    input  logic       cpu_rw_i,
    input  logic       cpu_rw_oe_i,
    output logic       fe_o,
    output logic [7:0] addr_lo_o,
    output logic       rw_lat_o
);

    logic       phase_q;
    logic [7:0] addr_lo_q;
    logic       rw_lat_q;

    // Phase history plus address-low/rw capture; the last phase-1 cycle wins
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= 1'b0;
            addr_lo_q <= 8'h00;
            rw_lat_q  <= 1'b0;
        end else begin
            phase_q <= cpu_phase_i;
            if (cpu_phase_i) begin
                addr_lo_q <= cpu_addr_mux_i;
                rw_lat_q  <= cpu_rw_i & cpu_rw_oe_i;
            end
        end
    end

    assign fe_o      = phase_q & ~cpu_phase_i;
    assign addr_lo_o = addr_lo_q;
    assign rw_lat_o  = rw_lat_q;

endmodule
`default_nettype wire

// File: rtl/cpu_bus_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : cpu_bus_bridge                                          |
// | Purpose  : Demultiplexes the 6502 core pin bus and runs one        |
// |            valid/ready memory transaction per CPU bus cycle        |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module cpu_bus_bridge
    import cpu_bus_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 15,
    parameter logic [7:0]  TIMEOUT_DATA = 8'hEA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_phase,
    input  logic [7:0]  cpu_addr_mux,
    input  logic [7:0]  cpu_uio_out,
    input  logic [7:0]  cpu_uio_oe,
    output logic [7:0]  cpu_uio_in,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_valid,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    output logic        bus_busy,
    output logic        err_timeout,
    output logic        err_overrun,
    output logic [15:0] cycle_count
);

    // Last REQ cycle index before the request is abandoned
    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT - 1);

    logic       fe;
    logic [7:0] addr_lo;
    logic       rw_lat;

    bus_phase_capture u_capture (
        .clk            (clk),
        .rst            (rst),
        .cpu_phase_i    (cpu_phase),
        .cpu_addr_mux_i (cpu_addr_mux),
        .cpu_rw_i       (cpu_uio_out[0]),
        .cpu_rw_oe_i    (cpu_uio_oe[0]),
        .fe_o           (fe),
        .addr_lo_o      (addr_lo),
        .rw_lat_o       (rw_lat)
    );

    bridge_state_e state_q, state_d;
    logic [15:0]   addr_q,  addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          we_q,    we_d;
    logic          valid_q, valid_d;
    logic [7:0]    rdata_q, rdata_d;
    logic [7:0]    tcnt_q,  tcnt_d;
    logic [15:0]   count_q, count_d;
    logic          tmo_q,   tmo_d;
    logic          ovr_q,   ovr_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            we_q    <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= 8'h00;
            tcnt_q  <= 8'h00;
            count_q <= 16'h0000;
            tmo_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            tcnt_q  <= tcnt_d;
            count_q <= count_d;
            tmo_q   <= tmo_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state: launch on phase falling edge, complete on ready or timeout
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        valid_d = valid_q;
        rdata_d = rdata_q;
        tcnt_d  = tcnt_q;
        count_d = count_q;
        tmo_d   = tmo_q;
        ovr_d   = ovr_q;

        unique case (state_q)
            IDLE, DONE: begin
                // A falling edge seen in DONE launches directly so no cycle is lost
                if (fe) begin
                    addr_d  = {cpu_addr_mux, addr_lo};
                    we_d    = rw_lat;
                    wdata_d = sel_wdata(rw_lat, cpu_uio_oe, cpu_uio_out);
                    valid_d = 1'b1;
                    tcnt_d  = 8'h00;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // A new bus cycle while busy is dropped; the current one carries on
                if (fe) begin
                    ovr_d = 1'b1;
                end
                if (mem_ready) begin
                    valid_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    count_d = count_q + 16'd1;
                    state_d = DONE;
                end else if (tcnt_q == TCNT_LAST) begin
                    valid_d = 1'b0;
                    tmo_d   = 1'b1;
                    if (!we_q) begin
                        rdata_d = TIMEOUT_DATA;
                    end
                    count_d = count_q + 16'd1;
                    state_d = DONE;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign cpu_uio_in  = rdata_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_we      = we_q;
    assign mem_valid   = valid_q;
    assign bus_busy    = (state_q != IDLE);
    assign err_timeout = tmo_q;
    assign err_overrun = ovr_q;
    assign cycle_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_cpu_bus_bridge                                       |
// | Purpose  : Directed self-checking bench for cpu_bus_bridge         |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_cpu_bus_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_phase;
    logic [7:0]  cpu_addr_mux;
    logic [7:0]  cpu_uio_out;
    logic [7:0]  cpu_uio_oe;
    logic [7:0]  cpu_uio_in;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_valid;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic        bus_busy;
    logic        err_timeout;
    logic        err_overrun;
    logic [15:0] cycle_count;

    int n_pass  = 0;
    int n_total = 0;

    cpu_bus_bridge #(.TIMEOUT(15), .TIMEOUT_DATA(8'hEA)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_phase    (cpu_phase),
        .cpu_addr_mux (cpu_addr_mux),
        .cpu_uio_out  (cpu_uio_out),
        .cpu_uio_oe   (cpu_uio_oe),
        .cpu_uio_in   (cpu_uio_in),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .bus_busy     (bus_busy),
        .err_timeout  (err_timeout),
        .err_overrun  (err_overrun),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One phase-1 cycle then switch to phase 0; returns just after the launch edge
    task automatic bus_cycle(input logic [7:0] lo, input logic [7:0] hi, input logic rw,
                             input logic [7:0] wd, input logic [7:0] oe_hi);
        cpu_phase    = 1'b1;
        cpu_addr_mux = lo;
        cpu_uio_out  = {7'b0, rw};
        cpu_uio_oe   = 8'h01;
        tick();
        cpu_phase    = 1'b0;
        cpu_addr_mux = hi;
        cpu_uio_out  = wd;
        cpu_uio_oe   = oe_hi;
        tick();
    endtask

    initial begin
        int vcnt;
        rst          = 1'b1;
        cpu_phase    = 1'b0;
        cpu_addr_mux = 8'h00;
        cpu_uio_out  = 8'h00;
        cpu_uio_oe   = 8'h00;
        mem_ready    = 1'b0;
        mem_rdata    = 8'h00;
        tick();
        tick();
        chk("rst_valid", 32'(mem_valid), 32'h0);
        chk("rst_busy", 32'(bus_busy), 32'h0);
        chk("rst_uio_in", 32'(cpu_uio_in), 32'h0);
        chk("rst_count", 32'(cycle_count), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        rst = 1'b0;
        tick();

        // Zero-wait read of 0x1234
        mem_ready = 1'b1;
        mem_rdata = 8'hA9;
        bus_cycle(8'h34, 8'h12, 1'b0, 8'h00, 8'h00);
        chk("rd_valid", 32'(mem_valid), 32'h1);
        chk("rd_addr", 32'(mem_addr), 32'h1234);
        chk("rd_we", 32'(mem_we), 32'h0);
        chk("rd_busy", 32'(bus_busy), 32'h1);
        tick();
        chk("rd_valid_drop", 32'(mem_valid), 32'h0);
        chk("rd_data", 32'(cpu_uio_in), 32'hA9);
        chk("rd_count", 32'(cycle_count), 32'h1);
        mem_ready = 1'b0;
        tick();
        chk("rd_idle", 32'(bus_busy), 32'h0);

        // Write 0x5C to 0x01FF
        mem_ready = 1'b1;
        bus_cycle(8'hFF, 8'h01, 1'b1, 8'h5C, 8'hFF);
        chk("wr_addr", 32'(mem_addr), 32'h01FF);
        chk("wr_we", 32'(mem_we), 32'h1);
        chk("wr_wdata", 32'(mem_wdata), 32'h5C);
        tick();
        chk("wr_uio_keep", 32'(cpu_uio_in), 32'hA9);
        chk("wr_count", 32'(cycle_count), 32'h2);
        mem_ready = 1'b0;
        tick();

        // Write with partial output enable carries zero data
        mem_ready = 1'b1;
        bus_cycle(8'h00, 8'h02, 1'b1, 8'h3C, 8'h0F);
        chk("wr_oe_wdata", 32'(mem_wdata), 32'h00);
        tick();
        mem_ready = 1'b0;
        tick();

        // Read with three wait states from 0x5678
        bus_cycle(8'h78, 8'h56, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            chk("ws_valid", 32'(mem_valid), 32'h1);
            chk("ws_addr", 32'(mem_addr), 32'h5678);
            if (i == 3) begin
                mem_ready = 1'b1;
                mem_rdata = 8'h77;
            end
            tick();
        end
        chk("ws_valid_drop", 32'(mem_valid), 32'h0);
        chk("ws_data", 32'(cpu_uio_in), 32'h77);
        chk("ws_no_tmo", 32'(err_timeout), 32'h0);
        chk("ws_count", 32'(cycle_count), 32'h4);
        mem_ready = 1'b0;
        tick();

        // Timeout on a read from 0x9ABC
        bus_cycle(8'hBC, 8'h9A, 1'b0, 8'h00, 8'h00);
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (mem_valid) begin
                vcnt++;
                tick();
            end
        end
        chk("tmo_valid_cycles", 32'(vcnt), 32'd15);
        chk("tmo_data", 32'(cpu_uio_in), 32'hEA);
        chk("tmo_flag", 32'(err_timeout), 32'h1);
        chk("tmo_count", 32'(cycle_count), 32'h5);
        tick();

        // Good read afterwards; timeout flag stays sticky
        mem_ready = 1'b1;
        mem_rdata = 8'h11;
        bus_cycle(8'h10, 8'h00, 1'b0, 8'h00, 8'h00);
        tick();
        chk("post_tmo_data", 32'(cpu_uio_in), 32'h11);
        chk("post_tmo_flag", 32'(err_timeout), 32'h1);
        mem_ready = 1'b0;
        tick();

        // Back-to-back: falling edge in DONE launches directly
        mem_ready = 1'b1;
        mem_rdata = 8'h21;
        bus_cycle(8'h01, 8'h40, 1'b0, 8'h00, 8'h00);
        cpu_phase    = 1'b1;
        cpu_addr_mux = 8'h02;
        cpu_uio_out  = 8'h00;
        tick();
        chk("b2b_done", 32'(mem_valid), 32'h0);
        cpu_phase    = 1'b0;
        cpu_addr_mux = 8'h41;
        tick();
        chk("b2b_valid", 32'(mem_valid), 32'h1);
        chk("b2b_addr", 32'(mem_addr), 32'h4102);
        tick();
        chk("b2b_count", 32'(cycle_count), 32'h8);
        mem_ready = 1'b0;
        tick();

        // Overrun: second falling edge while waiting on 0x3322
        bus_cycle(8'h22, 8'h33, 1'b0, 8'h00, 8'h00);
        cpu_phase    = 1'b1;
        cpu_addr_mux = 8'h44;
        tick();
        cpu_phase    = 1'b0;
        cpu_addr_mux = 8'h55;
        tick();
        chk("ovr_flag", 32'(err_overrun), 32'h1);
        chk("ovr_addr", 32'(mem_addr), 32'h3322);
        chk("ovr_valid", 32'(mem_valid), 32'h1);
        mem_ready = 1'b1;
        mem_rdata = 8'h66;
        tick();
        chk("ovr_data", 32'(cpu_uio_in), 32'h66);
        mem_ready = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_valid) vcnt++;
        end
        chk("ovr_no_launch", 32'(vcnt), 32'd0);
        chk("ovr_idle", 32'(bus_busy), 32'h0);

        // Reset in the middle of a request
        bus_cycle(8'hAA, 8'hBB, 1'b0, 8'h00, 8'h00);
        chk("mid_valid", 32'(mem_valid), 32'h1);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(mem_valid), 32'h0);
        chk("mid_rst_busy", 32'(bus_busy), 32'h0);
        chk("mid_rst_tmo", 32'(err_timeout), 32'h0);
        chk("mid_rst_ovr", 32'(err_overrun), 32'h0);
        chk("mid_rst_count", 32'(cycle_count), 32'h0);
        chk("mid_rst_uio", 32'(cpu_uio_in), 32'h0);
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
